cksum_ctrl: RTL

CKSUM_CTRL -- requirements
Module: cksum_ctrl

---
 rtl/cksum_ctrl_pkg.sv | 20 ++
 rtl/cksum_ctrl_if.sv | 20 ++
 rtl/byte_fifo.sv | 63 ++++++
 rtl/cksum_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/cksum_ctrl_pkg.sv
// Shared constants for the checksum controller: channel offsets, command bits, FSM encoding.
package cksum_ctrl_pkg;

  localparam logic [6:0] CH_DATA   = 7'd0;
  localparam logic [6:0] CH_CMD    = 7'd1;
  localparam logic [6:0] CH_STAT   = 7'd2;
  localparam logic [6:0] CH_SUM_LO = 7'd3;
  localparam logic [6:0] CH_SUM_HI = 7'd4;

  localparam int CMD_CLEAR_BIT = 0;
  localparam int CMD_HOLD_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_HOLD  = 2'b10,
    ST_CLEAR = 2'b11
  } state_e;

endpackage

// File: rtl/cksum_ctrl_if.sv
// Host channel bus: addressed byte writes (h2f) and byte reads (f2h).
interface cksum_ctrl_if;
  logic [6:0] chanAddr_in;
  logic [7:0] h2fData_in;
  logic       h2fValid_in;
  logic       h2fReady_out;
  logic [7:0] f2hData_out;
  logic       f2hValid_out;
  logic       f2hReady_in;

  modport master (
    output chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
    input  h2fReady_out, f2hData_out, f2hValid_out
  );

  modport slave (
    input  chanAddr_in, h2fData_in, h2fValid_in, f2hReady_in,
    output h2fReady_out, f2hData_out, f2hValid_out
  );
endinterface

// File: rtl/byte_fifo.sv
// Small byte FIFO with first-word fall-through read, synchronous flush and occupancy count.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  output logic [7:0]             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    // flush wins over a same-cycle push, so that byte is dropped
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/cksum_ctrl.sv
// Host-fed byte checksum engine: buffers bytes, sums them mod 2^16, exposes status over five channels.
module cksum_ctrl
  import cksum_ctrl_pkg::*;
#(
  parameter logic [6:0] CHAN_BASE  = 7'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  cksum_ctrl_if.slave bus,
  output logic [15:0] checksum_out,
  output logic        busy_out
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e      state_q, state_d;
  logic        hold_q, hold_d;
  logic [15:0] checksum_q, checksum_d;
  logic [7:0]  snap_q, snap_d;

  logic             sel_data, sel_cmd, sel_stat, sel_lo, sel_hi;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             cmd_wr, clear_cmd, rd_valid;
  logic [7:0]       rd_data;

  assign sel_data = (bus.chanAddr_in == CHAN_BASE + CH_DATA);
  assign sel_cmd  = (bus.chanAddr_in == CHAN_BASE + CH_CMD);
  assign sel_stat = (bus.chanAddr_in == CHAN_BASE + CH_STAT);
  assign sel_lo   = (bus.chanAddr_in == CHAN_BASE + CH_SUM_LO);
  assign sel_hi   = (bus.chanAddr_in == CHAN_BASE + CH_SUM_HI);

  // Writes to any channel other than the data port are always taken; unused ones vanish.
  assign bus.h2fReady_out = sel_data ? ~fifo_full : 1'b1;
  assign fifo_push  = sel_data & bus.h2fValid_in & ~fifo_full;
  assign fifo_pop   = (state_q == ST_ACCUM) & ~fifo_empty;
  assign fifo_flush = (state_q == ST_CLEAR);
  assign cmd_wr     = sel_cmd & bus.h2fValid_in;
  assign clear_cmd  = cmd_wr & bus.h2fData_in[CMD_CLEAR_BIT];

  assign busy_out     = ~fifo_empty | (state_q == ST_CLEAR);
  assign checksum_out = checksum_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_in),
    .srst_i  (reset_in),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (bus.h2fData_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    if (clear_cmd)                state_d = ST_CLEAR;
    else if (state_q == ST_CLEAR) state_d = ST_IDLE;
    else if (hold_q)              state_d = ST_HOLD;
    else begin
      unique case (state_q)
        ST_IDLE:  if (!fifo_empty) state_d = ST_ACCUM;
        ST_ACCUM: if (fifo_empty)  state_d = ST_IDLE;
        ST_HOLD:  state_d = fifo_empty ? ST_IDLE : ST_ACCUM;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Low byte is withheld while the sum is still moving so a 16-bit readout stays coherent.
  assign rd_valid = ~(sel_lo & ((state_q == ST_ACCUM) | (state_q == ST_CLEAR)));

  always_comb begin
    rd_data = 8'h00;
    if (sel_data)      rd_data = 8'(fifo_count);
    else if (sel_cmd)  rd_data = {6'b0, hold_q, 1'b0};
    else if (sel_stat) rd_data = {busy_out, state_q, 5'b0};
    else if (sel_lo)   rd_data = checksum_q[7:0];
    else if (sel_hi)   rd_data = snap_q;
  end

  assign bus.f2hData_out  = rd_data;
  assign bus.f2hValid_out = rd_valid;

  always_comb begin
    hold_d     = cmd_wr ? bus.h2fData_in[CMD_HOLD_BIT] : hold_q;
    checksum_d = checksum_q;
    if (state_q == ST_CLEAR) checksum_d = '0;
    else if (fifo_pop)       checksum_d = checksum_q + {8'h00, fifo_dout};
    snap_d = snap_q;
    if (sel_lo && rd_valid && bus.f2hReady_in) snap_d = checksum_q[15:8];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      hold_q     <= 1'b0;
      checksum_q <= '0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      checksum_q <= checksum_d;
      snap_q     <= snap_d;
    end
  end
endmodule
